// File: rtl/adc_hex_streamer.sv
// adc_hex_streamer: paces ADC conversions, queues samples in a FIFO and prints each as ASCII hex + CR LF.
// Optional macro ADC_SEQ_TAG_EN prefixes every line with a 4-bit sequence digit and ','.
`default_nettype none

module adc_hex_streamer #(
   parameter int SAMPLE_DIV = 50000,
   parameter int FIFO_AW    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               start,
   input  logic               done,
   input  logic [11:0]        data1,
   output logic [7:0]         TxD_data,
   output logic               TxD_start,
   input  logic               TxD_busy,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0]    PACE_LAST = CW'(SAMPLE_DIV - 1);
   localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
`ifdef ADC_SEQ_TAG_EN
   localparam int EW = 16;
   localparam logic [2:0] LAST_IDX = 3'd6;
`else
   localparam int EW = 12;
   localparam logic [2:0] LAST_IDX = 3'd4;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   logic [CW-1:0]      pace_cnt;
   logic [1:0]         state, state_nxt;
   logic [EW-1:0]      mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
   logic [EW-1:0]      entry_in, line;
   logic [2:0]         idx;
   logic [7:0]         cur_char;
   logic               full, empty, push, pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    pace_cnt <= '0;
      else if (!run)              pace_cnt <= '0;
      else if (pace_cnt == PACE_LAST) pace_cnt <= '0;
      else                        pace_cnt <= pace_cnt + 1'b1;
   end

   assign start = run && (pace_cnt == PACE_LAST);

   assign full  = (fifo_level == LEVEL_FULL);
   assign empty = (fifo_level == '0);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
   assign push  = done && (!full || pop);

`ifdef ADC_SEQ_TAG_EN
   logic [3:0] seq;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       seq <= 4'd0;
      else if (push) seq <= seq + 4'd1;
   end
   assign entry_in = {seq, data1};
`else
   assign entry_in = data1;
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= entry_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_level <= fifo_level + 1'b1;
         else if (pop && !push) fifo_level <= fifo_level - 1'b1;
         if (done && !push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!empty) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_SEND;
         S_SEND:  if (!TxD_busy) state_nxt = S_HOLD;
         default: state_nxt = (idx == LAST_IDX) ? S_IDLE : S_SEND;
      endcase
   end

   // HOLD is entered only from SEND with the UART idle, so the strobe lines up with TxD_data.
   always_comb begin
      TxD_start = (state == S_HOLD);
      pop       = (state == S_LOAD);
   end

   always_comb begin
      cur_char = 8'h0A;
`ifdef ADC_SEQ_TAG_EN
      case (idx)
         3'd0:    cur_char = hex_char(line[15:12]);
         3'd1:    cur_char = 8'h2C;
         3'd2:    cur_char = hex_char(line[11:8]);
         3'd3:    cur_char = hex_char(line[7:4]);
         3'd4:    cur_char = hex_char(line[3:0]);
         3'd5:    cur_char = 8'h0D;
         default: cur_char = 8'h0A;
      endcase
`else
      case (idx)
         3'd0:    cur_char = hex_char(line[11:8]);
         3'd1:    cur_char = hex_char(line[7:4]);
         3'd2:    cur_char = hex_char(line[3:0]);
         3'd3:    cur_char = 8'h0D;
         default: cur_char = 8'h0A;
      endcase
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line     <= '0;
         idx      <= 3'd0;
         TxD_data <= 8'h00;
      end else begin
         if (state == S_LOAD) begin
            line <= mem[rd_ptr];
            idx  <= 3'd0;
         end
         if (state == S_SEND && !TxD_busy) TxD_data <= cur_char;
         if (state == S_HOLD && idx != LAST_IDX) idx <= idx + 3'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_hex_streamer.sv
// Directed bench for adc_hex_streamer: table of single-line vectors plus pacing, overflow, reset and push/pop corners.
`default_nettype none

module tb_adc_hex_streamer;

   localparam int SAMPLE_DIV = 10;
   localparam int FIFO_AW    = 4;
   localparam int UART_CYC   = 4;

   logic               clk = 1'b0;
   logic               rst, run, done, hold_busy;
   logic [11:0]        data1;
   logic               start, TxD_start, overflow, TxD_busy;
   logic [7:0]         TxD_data;
   logic [FIFO_AW:0]   fifo_level;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int busy_cnt;
   logic [3:0] seq_m = 4'd0;
   logic [7:0] cap[$];
   logic [7:0] exp_q[$];
   int pulses[$];

   adc_hex_streamer #(.SAMPLE_DIV(SAMPLE_DIV), .FIFO_AW(FIFO_AW)) dut (
      .clk(clk), .rst(rst), .run(run), .start(start), .done(done), .data1(data1),
      .TxD_data(TxD_data), .TxD_start(TxD_start), .TxD_busy(TxD_busy),
      .fifo_level(fifo_level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Simple UART: busy for UART_CYC cycles after each start, or forced busy.
   always @(posedge clk or posedge rst) begin
      if (rst)            busy_cnt <= 0;
      else if (TxD_start) busy_cnt <= UART_CYC;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign TxD_busy = hold_busy || (busy_cnt != 0);

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (start) pulses.push_back(cyc);
      if (!rst && TxD_start) begin
         cap.push_back(TxD_data);
         n_cmp++;
         if (TxD_busy) begin
            n_fail++;
            $display("FAIL start_while_busy: TxD_start=1 with TxD_busy=%0b (required 0)", TxD_busy);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      logic [7:0] digits [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                  8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
      return digits[n];
   endfunction

   function automatic void add_prefix();
`ifdef ADC_SEQ_TAG_EN
      exp_q.push_back(hexc(seq_m));
      exp_q.push_back(8'h2C);
      seq_m = seq_m + 4'd1;
`endif
   endfunction

   function automatic void add_line(input logic [11:0] d);
      add_prefix();
      exp_q.push_back(hexc(d[11:8]));
      exp_q.push_back(hexc(d[7:4]));
      exp_q.push_back(hexc(d[3:0]));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endfunction

   task automatic pulse_done(input logic [11:0] d);
      @(negedge clk);
      data1 = d;
      done  = 1'b1;
      @(negedge clk);
      done  = 1'b0;
   endtask

   task automatic check_out(input string nm, input int budget);
      int t = 0;
      while (cap.size() < exp_q.size() && t < budget) begin
         @(posedge clk);
         t++;
      end
      repeat (40) @(posedge clk);
      chk({nm, " byte_count"}, cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < cap.size()) chk($sformatf("%s byte%0d", nm, i), cap[i], exp_q[i]);
      cap.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cap.delete();
      exp_q.delete();
      seq_m = 4'd0;
   endtask

   typedef struct {
      logic [11:0] d;
      logic [39:0] bytes;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{12'hABC, 40'h4142430D0A};
      vecs[1] = '{12'h09F, 40'h3039460D0A};
      vecs[2] = '{12'h000, 40'h3030300D0A};
      vecs[3] = '{12'hFFF, 40'h4646460D0A};
      vecs[4] = '{12'hA90, 40'h4139300D0A};

      rst = 1'b1; run = 1'b0; done = 1'b0; data1 = 12'h000; hold_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst start", start, 1'b0);
      chk("rst TxD_start", TxD_start, 1'b0);
      chk("rst TxD_data", TxD_data, 8'h00);
      chk("rst fifo_level", fifo_level, 0);
      chk("rst overflow", overflow, 1'b0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) begin
         add_prefix();
         for (int k = 0; k < 5; k++) exp_q.push_back(vecs[v].bytes[39 - 8*k -: 8]);
         pulse_done(vecs[v].d);
         check_out($sformatf("vec%0d", v), 500);
         chk($sformatf("vec%0d level", v), fifo_level, 0);
      end

      pulses.delete();
      @(negedge clk);
      run = 1'b1;
      repeat (35) @(negedge clk);
      run = 1'b0;
      chk("pace count", pulses.size(), 3);
      if (pulses.size() == 3) begin
         chk("pace spacing1", pulses[1] - pulses[0], SAMPLE_DIV);
         chk("pace spacing2", pulses[2] - pulses[1], SAMPLE_DIV);
      end
      pulses.delete();
      repeat (30) @(negedge clk);
      chk("pace stopped", pulses.size(), 0);

      // One sample sits in the line register while 17 more arrive; the 17th must drop.
      @(negedge clk);
      hold_busy = 1'b1;
      pulse_done(12'h7E1);
      add_line(12'h7E1);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         pulse_done(12'h800 + 12'(i * 17));
         if (i < 16) add_line(12'h800 + 12'(i * 17));
      end
      chk("fill level", fifo_level, 16);
      chk("fill overflow", overflow, 1'b1);
      @(negedge clk);
      hold_busy = 1'b0;
      check_out("drain", 3000);
      chk("drain level", fifo_level, 0);

      pulse_done(12'h3C5);
      pulse_done(12'h5AA);
      begin
         int t = 0;
         while (cap.size() < 2 && t < 200) begin
            @(posedge clk);
            t++;
         end
         chk("pre_reset bytes", cap.size() >= 2, 1'b1);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort TxD_start", TxD_start, 1'b0);
      chk("abort TxD_data", TxD_data, 8'h00);
      chk("abort level", fifo_level, 0);
      chk("abort overflow", overflow, 1'b0);
      chk("abort start", start, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cap.delete();
      exp_q.delete();
      seq_m = 4'd0;
      repeat (60) @(posedge clk);
      chk("no_resume bytes", cap.size(), 0);
      add_line(12'hD2E);
      pulse_done(12'hD2E);
      check_out("after_rst", 500);

      do_reset();
      @(negedge clk);
      hold_busy = 1'b1;
      pulse_done(12'h111);
      add_line(12'h111);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         pulse_done(12'hC00 + 12'(i));
         add_line(12'hC00 + 12'(i));
      end
      chk("pp full level", fifo_level, 16);
      chk("pp full overflow", overflow, 1'b0);
      @(negedge clk);
      hold_busy = 1'b0;
      begin
         int t = 0;
         while (cap.size() < 5 && t < 300) begin
            @(posedge clk);
            t++;
         end
      end
      // Now in IDLE; the following cycle is LOAD, where done coincides with the pop.
      @(posedge clk);
      @(negedge clk);
      data1 = 12'hEEE;
      done  = 1'b1;
      @(negedge clk);
      done  = 1'b0;
      chk("pp level", fifo_level, 16);
      chk("pp overflow", overflow, 1'b0);
      add_line(12'hEEE);
      check_out("pp drain", 3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
